// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and the
// default header tag base.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_DATA      = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } sched_state_t;

    localparam logic [7:0] DEFAULT_TAG_BASE = 8'hA0;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins,
// and the search wraps from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx among NUM_REQ byte requesters: round-robin grants, optional
// header byte per burst, burst cap, and a watchdog on the uart_tx handshake.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         DATA_BITS = 8,
    parameter int         TAG_EN    = 1,
    parameter logic [7:0] TAG_BASE  = DEFAULT_TAG_BASE,
    parameter int         MAX_BURST = 16,
    parameter int         TIMEOUT   = 64
) (
    input  logic                           clk_in,
    input  logic                           n_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_ready_in,
    output logic                           uart_en_out,
    output logic [DATA_BITS-1:0]           tx_data_out,
    output logic [NUM_REQ-1:0]             grant_out,
    output logic                           busy_out,
    output logic                           err_timeout_out
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    sched_state_t         state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [BURST_W-1:0]   burst_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 last_flag;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [DATA_BITS-1:0] arb_tag;

    logic [IDX_W-1:0]     ptr_nxt;
    logic [IDX_W-1:0]     sel_idx;
    logic [NUM_REQ-1:0]   sel_grant;
    logic [DATA_BITS-1:0] sel_data;
    logic                 sel_last;
    logic [BURST_W-1:0]   sel_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign arb_tag  = DATA_BITS'(TAG_BASE) | DATA_BITS'(arb_idx);
    assign ptr_nxt  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign busy_out = (state != ST_IDLE);

    // A data launch comes either straight from IDLE (no header) or from WAIT_HIGH.
    assign sel_idx   = (state == ST_IDLE) ? arb_idx   : grant_idx;
    assign sel_grant = (state == ST_IDLE) ? arb_grant : grant_out;
    assign sel_cnt   = (state == ST_IDLE) ? BURST_W'(1) : burst_cnt + BURST_W'(1);
    assign sel_data  = req_data[sel_idx*DATA_BITS +: DATA_BITS];
    assign sel_last  = req_last[sel_idx];

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            grant_idx       <= '0;
            grant_out       <= '0;
            burst_cnt       <= '0;
            tmo_cnt         <= '0;
            last_flag       <= 1'b0;
            req_ready       <= '0;
            uart_en_out     <= 1'b0;
            tx_data_out     <= '0;
            err_timeout_out <= 1'b0;
        end else begin
            uart_en_out <= 1'b0;
            tx_data_out <= '0;
            req_ready   <= '0;
            case (state)
                ST_IDLE: begin
                    if (tx_ready_in && arb_any) begin
                        grant_out <= arb_grant;
                        grant_idx <= arb_idx;
                        if (TAG_EN != 0) begin
                            state       <= ST_HDR;
                            burst_cnt   <= '0;
                            last_flag   <= 1'b0;
                            uart_en_out <= 1'b1;
                            tx_data_out <= arb_tag;
                        end else begin
                            state       <= ST_DATA;
                            burst_cnt   <= sel_cnt;
                            last_flag   <= sel_last || (sel_cnt == BURST_W'(MAX_BURST));
                            uart_en_out <= 1'b1;
                            tx_data_out <= sel_data;
                            req_ready   <= sel_grant;
                        end
                    end
                end
                ST_HDR, ST_DATA: begin
                    state   <= ST_WAIT_LOW;
                    tmo_cnt <= '0;
                end
                ST_WAIT_LOW: begin
                    if (!tx_ready_in) begin
                        state <= ST_WAIT_HIGH;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // uart_tx never acknowledged the launch: give up on this owner.
                        err_timeout_out <= 1'b1;
                        grant_out       <= '0;
                        ptr             <= ptr_nxt;
                        state           <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (tx_ready_in) begin
                        if (!last_flag && req_valid[grant_idx]) begin
                            state       <= ST_DATA;
                            burst_cnt   <= sel_cnt;
                            last_flag   <= sel_last || (sel_cnt == BURST_W'(MAX_BURST));
                            uart_en_out <= 1'b1;
                            tx_data_out <= sel_data;
                            req_ready   <= sel_grant;
                        end else begin
                            grant_out <= '0;
                            ptr       <= ptr_nxt;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    grant_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester queues and a uart_tx ready
// model drive the DUT; a monitor checks every launched byte against expectations.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DATA_BITS = 8;

    logic                         clk_in = 1'b0;
    logic                         n_rst  = 1'b0;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         tx_ready_in;
    logic                         uart_en_out;
    logic [DATA_BITS-1:0]         tx_data_out;
    logic [NUM_REQ-1:0]           grant_out;
    logic                         busy_out;
    logic                         err_timeout_out;

    always #5 clk_in = ~clk_in;

    uart_tx_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .DATA_BITS (DATA_BITS),
        .TAG_EN    (1),
        .TAG_BASE  (8'hA0),
        .MAX_BURST (16),
        .TIMEOUT   (64)
    ) dut (
        .clk_in          (clk_in),
        .n_rst           (n_rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .tx_ready_in     (tx_ready_in),
        .uart_en_out     (uart_en_out),
        .tx_data_out     (tx_data_out),
        .grant_out       (grant_out),
        .busy_out        (busy_out),
        .err_timeout_out (err_timeout_out)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
        logic       hdr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   launches = 0;

    logic [7:0] ch_data [NUM_REQ][64];
    logic       ch_last [NUM_REQ][64];
    int         wr_cnt [NUM_REQ];
    int         rd_cnt [NUM_REQ];
    int         rdy_pulses [NUM_REQ];

    // uart_tx model: 0 = ready held low, 1 = normal handshake, 2 = ready stuck high
    int tx_mode = 0;
    int tx_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic add_byte(input int ch, input logic [7:0] d, input logic last);
        ch_data[ch][wr_cnt[ch]] = d;
        ch_last[ch][wr_cnt[ch]] = last;
        wr_cnt[ch]++;
    endtask

    task automatic push_exp(input logic [7:0] d, input int ch, input logic hdr);
        exp_t e;
        e.data = d;
        e.ch   = 2'(ch);
        e.hdr  = hdr;
        exp_q.push_back(e);
    endtask

    task automatic flush_requesters();
        for (int i = 0; i < NUM_REQ; i++) wr_cnt[i] = rd_cnt[i];
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk_in);
            #1;
            cyc++;
        end while (!(exp_q.size() == 0 && !busy_out) && cyc < 3000);
        check({name, "_done"}, 32'(cyc >= 3000), 32'h0);
        tick(3);
    endtask

    task automatic do_reset();
        tx_mode = 0;
        n_rst   = 1'b0;
        flush_requesters();
        exp_q.delete();
        tick(3);
        n_rst = 1'b1;
        tick(2);
        tx_mode = 1;
        tick(2);
    endtask

    // Requesters: present the head of each channel queue, advance on req_ready.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk_in);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    rd_cnt[i]++;
                    rdy_pulses[i]++;
                end
                if (rd_cnt[i] < wr_cnt[i]) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*8 +: 8]    = ch_data[i][rd_cnt[i]];
                    req_last[i]           = ch_last[i][rd_cnt[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // uart_tx ready model: drops ready after a launch, raises it three cycles later.
    initial begin
        tx_ready_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            case (tx_mode)
                0: begin
                    tx_ready_in = 1'b0;
                    tx_busy     = 0;
                end
                1: begin
                    if (uart_en_out) begin
                        tx_busy     = 3;
                        tx_ready_in = 1'b0;
                    end else if (tx_busy > 0) begin
                        tx_busy--;
                        if (tx_busy == 0) tx_ready_in = 1'b1;
                    end else begin
                        tx_ready_in = 1'b1;
                    end
                end
                default: tx_ready_in = 1'b1;
            endcase
        end
    end

    // Monitor: every launch must match the head of the scoreboard and follow a
    // low-then-high ready sequence since the previous launch.
    logic saw_low   = 1'b0;
    logic ok_launch = 1'b0;
    initial begin
        exp_t             e;
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] er;
        forever begin
            @(negedge clk_in);
            if (uart_en_out) begin
                launches++;
                n_checks++;
                if (!ok_launch) begin
                    n_fail++;
                    $display("FAIL launch_spacing: launch of %0h without ready low-then-high", tx_data_out);
                end
                ok_launch = 1'b0;
                saw_low   = 1'b0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_launch: got data %0h grant %b, expected no launch", tx_data_out, grant_out);
                end else begin
                    e  = exp_q.pop_front();
                    eg = 4'b0001 << e.ch;
                    er = e.hdr ? 4'b0000 : eg;
                    if (tx_data_out !== e.data || grant_out !== eg || req_ready !== er) begin
                        n_fail++;
                        $display("FAIL launch: got data %0h grant %b ready %b, expected data %0h grant %b ready %b",
                                 tx_data_out, grant_out, req_ready, e.data, eg, er);
                    end
                end
            end
            if (!tx_ready_in) saw_low = 1'b1;
            else if (saw_low) ok_launch = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int lat;
        int base_launch;
        int base_rd;

        // Reset state
        n_rst   = 1'b0;
        tx_mode = 0;
        tick(3);
        check("rst_grant", 32'(grant_out), 32'h0);
        check("rst_busy", 32'(busy_out), 32'h0);
        check("rst_err", 32'(err_timeout_out), 32'h0);
        check("rst_en", 32'(uart_en_out), 32'h0);
        check("rst_data", 32'(tx_data_out), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        n_rst = 1'b1;
        tick(2);

        // Single byte on channel 0, held off while uart_tx ready is still low
        add_byte(0, 8'h55, 1'b1);
        push_exp(8'hA0, 0, 1'b1);
        push_exp(8'h55, 0, 1'b0);
        tick(10);
        check("no_launch_ready_low", 32'(launches), 32'h0);
        tx_mode = 1;
        wait_idle("single");
        check("single_ready_pulses", 32'(rdy_pulses[0]), 32'h1);
        check("single_grant_released", 32'(grant_out), 32'h0);
        check("single_busy", 32'(busy_out), 32'h0);

        // Contention: all four at once from pointer 0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) add_byte(i, 8'(8'h10 + i), 1'b1);
        for (int i = 0; i < NUM_REQ; i++) begin
            push_exp(8'(8'hA0 + i), i, 1'b1);
            push_exp(8'(8'h10 + i), i, 1'b0);
        end
        wait_idle("contention");
        // Pointer is back at 0, so channel 0 beats channel 3
        add_byte(3, 8'h23, 1'b1);
        add_byte(0, 8'h20, 1'b1);
        push_exp(8'hA0, 0, 1'b1);
        push_exp(8'h20, 0, 1'b0);
        push_exp(8'hA3, 3, 1'b1);
        push_exp(8'h23, 3, 1'b0);
        wait_idle("ptr_wrap");

        // Burst cap: 20 bytes on channel 2 split into 16 + 4 with a fresh header
        do_reset();
        for (int k = 0; k < 20; k++) add_byte(2, 8'(8'h40 + k), 1'b0);
        push_exp(8'hA2, 2, 1'b1);
        for (int k = 0; k < 16; k++) push_exp(8'(8'h40 + k), 2, 1'b0);
        push_exp(8'hA2, 2, 1'b1);
        for (int k = 16; k < 20; k++) push_exp(8'(8'h40 + k), 2, 1'b0);
        wait_idle("burst_cap");
        check("burst_drained", 32'(wr_cnt[2] - rd_cnt[2]), 32'h0);

        // Valid drop on channel 1 after two bytes; pointer then sits at 2
        do_reset();
        add_byte(1, 8'h61, 1'b0);
        add_byte(1, 8'h62, 1'b0);
        push_exp(8'hA1, 1, 1'b1);
        push_exp(8'h61, 1, 1'b0);
        push_exp(8'h62, 1, 1'b0);
        wait_idle("valid_drop");
        check("drop_grant", 32'(grant_out), 32'h0);
        for (int i = 0; i < NUM_REQ; i++) add_byte(i, 8'(8'h70 + i), 1'b1);
        for (int n = 0; n < NUM_REQ; n++) begin
            push_exp(8'(8'hA0 + ((n + 2) % 4)), (n + 2) % 4, 1'b1);
            push_exp(8'(8'h70 + ((n + 2) % 4)), (n + 2) % 4, 1'b0);
        end
        wait_idle("after_drop");

        // Timeout: uart_tx ready never falls after the header launch
        do_reset();
        tx_mode = 2;
        add_byte(0, 8'h80, 1'b0);
        push_exp(8'hA0, 0, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!uart_en_out && cyc < 200);
        check("tmo_launch_seen", 32'(cyc >= 200), 32'h0);
        flush_requesters();
        base_launch = launches;
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (!err_timeout_out && lat < 200);
        // One HDR cycle, then 64 WAIT_LOW cycles before the flag registers
        check("tmo_latency", 32'(lat), 32'd65);
        check("tmo_grant", 32'(grant_out), 32'h0);
        check("tmo_busy", 32'(busy_out), 32'h0);
        tick(5);
        check("tmo_sticky", 32'(err_timeout_out), 32'h1);
        check("tmo_no_relaunch", 32'(launches - base_launch), 32'h0);

        // Reset in the middle of a burst, while byte 3 is on the line
        do_reset();
        check("rst_clears_err", 32'(err_timeout_out), 32'h0);
        base_rd = rd_cnt[0];
        for (int k = 0; k < 6; k++) add_byte(0, 8'(8'h30 + k), 1'b0);
        push_exp(8'hA0, 0, 1'b1);
        push_exp(8'h30, 0, 1'b0);
        push_exp(8'h31, 0, 1'b0);
        push_exp(8'h32, 0, 1'b0);
        cyc = 0;
        do begin
            @(posedge clk_in);
            #1;
            cyc++;
        end while (!(uart_en_out && tx_data_out == 8'h32) && cyc < 500);
        check("mid_byte3_seen", 32'(cyc >= 500), 32'h0);
        n_rst   = 1'b0;
        tx_mode = 0;
        @(negedge clk_in);
        check("mid_rst_en", 32'(uart_en_out), 32'h0);
        check("mid_rst_data", 32'(tx_data_out), 32'h0);
        check("mid_rst_grant", 32'(grant_out), 32'h0);
        check("mid_rst_busy", 32'(busy_out), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_accepted", 32'(rd_cnt[0] - base_rd), 32'h2);
        exp_q.delete();
        flush_requesters();
        tick(2);
        n_rst = 1'b1;
        add_byte(1, 8'h91, 1'b1);
        push_exp(8'hA1, 1, 1'b1);
        push_exp(8'h91, 1, 1'b0);
        base_launch = launches;
        tick(10);
        check("mid_no_launch_ready_low", 32'(launches - base_launch), 32'h0);
        tx_mode = 1;
        wait_idle("after_mid_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one uart_tx.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: byte width, equal to the uart_tx DATA_BITS.
REQ-003 The block SHALL have parameter TAG_EN, default 1: when 1, a header byte precedes each burst.
REQ-004 The block SHALL have parameter TAG_BASE, default 8'hA0: header byte = TAG_BASE | channel index.
REQ-005 The block SHALL have parameter MAX_BURST, default 16: maximum data bytes per grant.
REQ-006 The block SHALL have parameter TIMEOUT, default 64: cycles allowed for tx_ready_in to fall after a launch.
REQ-007 The block SHALL have port clk_in  input  1  clock; all logic on its rising edge.
REQ-008 The block SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-009 The block SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-010 The block SHALL have port req_data  input  NUM_REQ*DATA_BITS  packed bytes; channel i at [i*DATA_BITS +: DATA_BITS].
REQ-011 The block SHALL have port req_last  input  NUM_REQ  current byte ends the requester's burst.
REQ-012 The block SHALL have port req_ready  output  NUM_REQ  one-cycle pulse: byte accepted.
REQ-013 The block SHALL have port tx_ready_in  input  1  from uart_tx ready_out.
REQ-014 The block SHALL have port uart_en_out  output  1  one-cycle launch pulse to uart_tx uart_en.
REQ-015 The block SHALL have port tx_data_out  output  DATA_BITS  byte to uart_tx data_in, valid while uart_en_out=1.
REQ-016 The block SHALL have port grant_out  output  NUM_REQ  one-hot current owner, zero when idle.
REQ-017 The block SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-018 The block SHALL have port err_timeout_out  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, HDR, DATA, WAIT_LOW, WAIT_HIGH; all outputs are registered or decoded from state (Moore).
REQ-020 IDLE: with tx_ready_in=1 and any req_valid, the FSM SHALL latch a round-robin winner into grant_out, clear the burst counter, and go to HDR (TAG_EN=1) or DATA (TAG_EN=0).
REQ-021 Round-robin: the search SHALL start at pointer index, wrapping NUM_REQ-1 -> 0; on grant release, pointer = granted index + 1 modulo NUM_REQ.
REQ-022 HDR (one cycle): uart_en_out=1, tx_data_out=TAG_BASE|index; next state WAIT_LOW; no req_ready.
REQ-023 DATA (one cycle): uart_en_out=1, tx_data_out=granted req_data, req_ready[granted]=1; burst counter +1; last flag = req_last[granted] OR counter reaching MAX_BURST; next state WAIT_LOW.
REQ-024 Requesters SHALL hold req_data and req_last stable while req_valid=1 and req_ready is low.
REQ-025 WAIT_LOW: on tx_ready_in=0, the FSM SHALL go to WAIT_HIGH; after TIMEOUT cycles without it, it SHALL set err_timeout_out, clear grant_out, advance the pointer, and go to IDLE.
REQ-026 WAIT_HIGH: on tx_ready_in=1, the FSM SHALL go to DATA if the last flag is clear and req_valid[granted]=1; otherwise it SHALL release the grant, advance the pointer, and go to IDLE.
REQ-027 Release on req_valid[granted]=0 in WAIT_HIGH SHALL occur even mid-burst; no header is resent until the next grant.
REQ-028 Simultaneous requests SHALL be ordered by pointer only; a requester asserting valid during another's burst SHALL wait for release.
REQ-029 uart_en_out SHALL never be asserted twice without an intervening tx_ready_in low-then-high sequence.

Reset
REQ-030 On n_rst low: state=IDLE, grant_out=0, req_ready=0, uart_en_out=0, tx_data_out=0, busy_out=0, err_timeout_out=0, pointer=0, counters=0.
REQ-031 A reset during a burst SHALL abort it; the interrupted byte is not retried.
REQ-032 After reset, no launch SHALL occur until tx_ready_in=1 (uart_tx ready resets low).

Structure
REQ-033 Package uart_sched_pkg SHALL hold the state encoding and default TAG_BASE constant.
REQ-034 Sub-module rr_arbiter SHALL hold the combinational round-robin picker (inputs req, pointer; outputs one-hot grant, index, any).
REQ-035 Counter widths SHALL be $clog2(MAX_BURST+1) and $clog2(TIMEOUT+1).

Verification
REQ-036 Single: req_valid=0001, data 8'h55, last=1 -> header 8'hA0, then 8'h55 on the uart_tx line; req_ready[0] pulses once; grant released.
REQ-037 Contention: all four valid, one byte each, last=1 -> header order A0,A1,A2,A3; pointer returns to 0.
REQ-038 Burst cap: channel 2 holds valid 20 bytes, last=0 -> 16 data bytes, release, then re-grant with new header A2 and remaining 4 bytes.
REQ-039 Timeout: tx_ready_in held 1 after launch -> err_timeout_out=1 after 64 cycles, IDLE, grant_out=0.
REQ-040 Mid-burst reset: n_rst low during byte 3 -> all outputs zero next cycle; no uart_en_out until tx_ready_in=1.
REQ-041 Valid drop: channel 1 deasserts valid after 2 bytes -> release in WAIT_HIGH, pointer=2.
